// File: rtl/wb_dma_pkg.sv
// Shared types and constants for the Wishbone byte-copy DMA.
package wb_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FIN
    } state_t;

    localparam logic [2:0] CTI_CLASSIC     = 3'b000;
    localparam int         TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/wishbone_dma_timer.sv
// Per-access watchdog: counts no-ack cycles of one bus access and flags
// the cycle in which the TIMEOUT'th unacknowledged cycle is reached.
module wishbone_dma_timer
    import wb_dma_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Counter holds the number of completed wait cycles, so the current one is r_cnt+1.
    assign expired_o = en_i && (r_cnt == LIMIT);

endmodule

// File: rtl/wishbone_dma.sv
// Wishbone classic initiator copying len_i bytes src->dst, one read + one write per byte.
// Define WB_DMA_FILL_EN to add fill mode (write fill_data_i to every dst byte, no reads).
module wishbone_dma
    import wb_dma_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_BYTES    = 1,
    parameter int TIMEOUT       = TIMEOUT_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDRESS_WIDTH-1:0] src_i,
    input  logic [ADDRESS_WIDTH-1:0] dst_i,
    input  logic [15:0]              len_i,
`ifdef WB_DMA_FILL_EN
    input  logic                     fill_i,
    input  logic [DATA_WIDTH-1:0]    fill_data_i,
`endif
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [ADDRESS_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic                     we_o,
    output logic [DATA_BYTES-1:0]    sel_o,
    output logic                     stb_o,
    output logic                     cyc_o,
    input  logic                     ack_i,
    output logic [2:0]               cti_o
);

    localparam logic [ADDRESS_WIDTH-1:0] ADR_ONE = ADDRESS_WIDTH'(1);

    state_t                   r_state;
    logic [ADDRESS_WIDTH-1:0] r_src, r_dst, r_adr;
    logic [15:0]              r_len;
    logic [DATA_WIDTH-1:0]    r_byte, r_dat;
    logic [DATA_BYTES-1:0]    r_sel;
    logic                     r_cyc, r_stb, r_we, r_busy, r_done, r_err;

    logic                     w_access, w_expired;
    logic [ADDRESS_WIDTH-1:0] w_src_inc, w_dst_inc;
    logic                     w_fill, w_fill_start;
    logic [DATA_WIDTH-1:0]    w_fill_data, w_fill_data_start;

`ifdef WB_DMA_FILL_EN
    logic                  r_fill;
    logic [DATA_WIDTH-1:0] r_fill_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill      <= 1'b0;
            r_fill_data <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_fill      <= fill_i;
            r_fill_data <= fill_data_i;
        end
    end

    assign w_fill            = r_fill;
    assign w_fill_data       = r_fill_data;
    assign w_fill_start      = fill_i;
    assign w_fill_data_start = fill_data_i;
`else
    assign w_fill            = 1'b0;
    assign w_fill_data       = '0;
    assign w_fill_start      = 1'b0;
    assign w_fill_data_start = '0;
`endif

    assign w_access  = (r_state == RD) || (r_state == WR);
    assign w_src_inc = r_src + ADR_ONE;
    assign w_dst_inc = r_dst + ADR_ONE;

    // Held clear outside RD/WR, so every access starts counting from zero.
    wishbone_dma_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!w_access),
        .en_i      (w_access && !ack_i),
        .expired_o (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_byte  <= '0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start_i) begin
                    r_src  <= src_i;
                    r_dst  <= dst_i;
                    r_len  <= len_i;
                    r_err  <= 1'b0;
                    r_busy <= 1'b1;
                    if (len_i == 16'd0) begin
                        r_state <= FIN;
                    end else begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_sel <= '1;
                        if (w_fill_start) begin
                            r_state <= WR;
                            r_we    <= 1'b1;
                            r_adr   <= dst_i;
                            r_dat   <= w_fill_data_start;
                        end else begin
                            r_state <= RD;
                            r_we    <= 1'b0;
                            r_adr   <= src_i;
                        end
                    end
                end
                RD, WR: if (ack_i || w_expired) begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
                    r_sel <= '0;
                    if (ack_i) begin
                        if (r_state == RD) r_byte <= dat_i;
                        r_state <= (r_state == RD) ? RD_GAP : WR_GAP;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= FIN;
                    end
                end
                RD_GAP: begin
                    r_state <= WR;
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we    <= 1'b1;
                    r_sel   <= '1;
                    r_adr   <= r_dst;
                    r_dat   <= r_byte;
                end
                WR_GAP: begin
                    r_src <= w_src_inc;
                    r_dst <= w_dst_inc;
                    r_len <= r_len - 16'd1;
                    if (r_len == 16'd1) begin
                        r_state <= FIN;
                    end else begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                        r_sel <= '1;
                        if (w_fill) begin
                            r_state <= WR;
                            r_we    <= 1'b1;
                            r_adr   <= w_dst_inc;
                            r_dat   <= w_fill_data;
                        end else begin
                            r_state <= RD;
                            r_we    <= 1'b0;
                            r_adr   <= w_src_inc;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign err_o  = r_err;
    assign adr_o  = r_adr;
    assign dat_o  = r_dat;
    assign we_o   = r_we;
    assign sel_o  = r_sel;
    assign stb_o  = r_stb;
    assign cyc_o  = r_cyc;
    assign cti_o  = CTI_CLASSIC;

endmodule

// File: doc/wishbone_dma.md
WISHBONE_DMA -- requirements
Module: wishbone_dma

Interface
REQ-001 Parameters SHALL be:
- ADDRESS_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 8, Wishbone data width.
- DATA_BYTES, 1, select width.
- TIMEOUT, 255, maximum cycles to wait for ack_i per access (1..255).

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous active-high reset.
- start_i, in, 1, start a transfer.
- src_i, in, ADDRESS_WIDTH, source base address.
- dst_i, in, ADDRESS_WIDTH, destination base address.
- len_i, in, 16, byte count.
- busy_o, out, 1, transfer in progress.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, sticky timeout flag.
- adr_o, out, ADDRESS_WIDTH, Wishbone address.
- dat_o, out, DATA_WIDTH, write data.
- dat_i, in, DATA_WIDTH, read data.
- we_o, out, 1, write enable.
- sel_o, out, DATA_BYTES, byte select.
- stb_o, out, 1, strobe.
- cyc_o, out, 1, cycle.
- ack_i, in, 1, acknowledge.
- cti_o, out, 3, cycle type.

REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high, with the clock named clk_i and the reset named rst_i.

Function
REQ-004 The block SHALL act as a Wishbone classic initiator that copies len_i bytes from src_i.. to dst_i.. one byte at a time: read, then write.
REQ-005 The state machine SHALL have states IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
REQ-006 IDLE SHALL transition on start_i as follows:
- It SHALL latch src_i, dst_i and len_i.
- If len_i==0 it SHALL go to FIN, with no bus activity.
- Otherwise it SHALL go to RD.
REQ-007 RD SHALL drive cyc_o=stb_o=1, we_o=0 and adr_o=src; on ack_i it SHALL capture dat_i into a byte register and go to RD_GAP.
REQ-008 WR SHALL drive cyc_o=stb_o=1, we_o=1, adr_o=dst and dat_o=byte register; on ack_i it SHALL go to WR_GAP.
REQ-009 In RD_GAP and WR_GAP, cyc_o and stb_o SHALL be 0 for exactly one cycle, so that a registered slave's trailing ack is never taken as the next access's ack.
REQ-010 WR_GAP SHALL increment src and dst and decrement the count; it SHALL then go to FIN if the count reaches 0, else to RD.
REQ-011 FIN SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-012 busy_o SHALL be 1 in every state except IDLE.
REQ-013 start_i SHALL be ignored while busy_o=1.
REQ-014 start_i SHALL be accepted in the cycle immediately after done_o.
REQ-015 sel_o SHALL be all-ones and cti_o SHALL be 3'b000 (classic) whenever cyc_o=1.
REQ-016 Address increments SHALL wrap modulo 2^ADDRESS_WIDTH (0xFFFF+1 -> 0x0000) without an error.
REQ-017 ack_i SHALL be ignored outside RD and WR.
REQ-018 A per-access counter SHALL clear on entry to RD or WR and increment each cycle without ack_i.
REQ-019 When the counter reaches TIMEOUT, the block SHALL:
- drop cyc_o and stb_o on the next edge;
- set err_o;
- go to FIN (done_o still pulses).
REQ-020 err_o SHALL clear only on an accepted start_i or on reset.
REQ-021 The minimum cost per byte with zero-wait slaves SHALL be 4 cycles: RD, RD_GAP, WR, WR_GAP.

Reset
REQ-022 On rst_i, including mid-transfer, the next edge SHALL force IDLE and clear all of the following to 0: cyc_o, stb_o, we_o, busy_o, done_o, err_o, adr_o, dat_o, sel_o, cti_o, and the internal counters.
REQ-023 No bus strobe SHALL be asserted in the cycle after rst_i deasserts.

Configuration
REQ-024 Macro WB_DMA_FILL_EN SHALL control fill mode.
REQ-025 When WB_DMA_FILL_EN is defined:
- inputs fill_i (1 bit) and fill_data_i (DATA_WIDTH bits) SHALL exist and be latched at start_i;
- if fill_i=1, the RD and RD_GAP states SHALL be skipped and each write SHALL use fill_data_i, at 2 cycles per byte;
- the src address SHALL not be used.
REQ-026 When WB_DMA_FILL_EN is undefined, those ports and that logic SHALL be absent, and behaviour SHALL be copy-only.

Structure
REQ-027 Shared package wb_dma_pkg SHALL hold the state enumeration typedef, the CTI_CLASSIC constant (3'b000) and the TIMEOUT default.
REQ-028 Sub-module wishbone_dma_timer SHALL implement the per-access timeout counter, with clear, enable and expired signals.

Verification
REQ-029 The bench SHALL attach two 512-byte registered-ack slave memories at 0x0000 and 0x1000.
REQ-030 The bench SHALL cover these scenarios:
- Copy test: src=0x0010, dst=0x1020, len=4 with source bytes 11 22 33 44 -> dst bytes 11 22 33 44, done_o after 4 bytes at minimum 4 cycles/byte, err_o=0.
- Zero length: len=0 -> done_o 2 cycles after start_i, cyc_o never 1.
- Timeout: src=0x8000 (no slave acks), TIMEOUT=8 -> cyc_o high for 8 cycles then low, err_o=1, done_o pulses, no write issued.
- Reset mid-transfer: rst_i asserted during WR of byte 2 of 5 -> cyc_o=0 and busy_o=0 next edge, dst bytes 3..5 unchanged.
- Wrap and busy: start while busy is ignored; src=0x01FF, len=2 with only the 0x0000 memory valid -> second read times out at adr_o=0x0200 and does not alias to 0x0000.
- Fill mode (WB_DMA_FILL_EN defined): fill_i=1, fill_data_i=0xA5, dst=0x1000, len=3 -> 0x1000..0x1002 = A5, no read cycles (we_o=1 whenever cyc_o=1).
